// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: scans a screen-clipped rectangle and issues one framebuffer write per clock.
// Optional build macro RECT_OUTLINE_EN adds an `outline` input that restricts plotting to edge pixels.
module rect_fill_engine #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int CW       = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] w,
  input  logic [YW-1:0] h,
  input  logic [CW-1:0] fill_color,
`ifdef RECT_OUTLINE_EN
  input  logic          outline,
`endif
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] color,
  output logic          plot
);

  localparam logic [XW:0]   X_LIM = (XW+1)'(SCREEN_W);
  localparam logic [YW:0]   Y_LIM = (YW+1)'(SCREEN_H);
  localparam logic [XW:0]   X_ONE = {{XW{1'b0}}, 1'b1};
  localparam logic [YW:0]   Y_ONE = {{YW{1'b0}}, 1'b1};
  localparam logic [XW-1:0] X_INC = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [YW-1:0] Y_INC = {{(YW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [XW-1:0] xs_r, xs_s, cx_r, cx_s, nx_s, x_s;
  logic [YW-1:0] cy_r, cy_s, ny_s, y_s;
  logic [XW:0]   xe_r, xe_s, x_sum_s, x_clip_s;
  logic [YW:0]   ye_r, ye_s, y_sum_s, y_clip_s;
  logic [CW-1:0] fill_r, fill_s, color_s;
  logic          busy_s, done_s, plot_s;
  logic          empty_s, row_end_s, last_s, edge_s;
`ifdef RECT_OUTLINE_EN
  logic [YW-1:0] ys_r, ys_s;
  logic          outline_r, outline_s;
`endif

  // Clip the requested extent to the screen and classify requests with no visible pixel.
  always_comb begin
    x_sum_s = {1'b0, x0} + {1'b0, w};
    y_sum_s = {1'b0, y0} + {1'b0, h};
    if (x_sum_s > X_LIM) begin
      x_clip_s = X_LIM;
    end else begin
      x_clip_s = x_sum_s;
    end
    if (y_sum_s > Y_LIM) begin
      y_clip_s = Y_LIM;
    end else begin
      y_clip_s = y_sum_s;
    end
    empty_s = (w == {XW{1'b0}}) || (h == {YW{1'b0}}) ||
              ({1'b0, x0} >= X_LIM) || ({1'b0, y0} >= Y_LIM);
  end

  // Row-major successor of the current scan position and its edge classification.
  always_comb begin
    row_end_s = (({1'b0, cx_r} + X_ONE) == xe_r);
    last_s    = row_end_s && (({1'b0, cy_r} + Y_ONE) == ye_r);
    if (row_end_s) begin
      nx_s = xs_r;
      ny_s = cy_r + Y_INC;
    end else begin
      nx_s = cx_r + X_INC;
      ny_s = cy_r;
    end
`ifdef RECT_OUTLINE_EN
    edge_s = !outline_r || (nx_s == xs_r) || (({1'b0, nx_s} + X_ONE) == xe_r) ||
             (ny_s == ys_r) || (({1'b0, ny_s} + Y_ONE) == ye_r);
`else
    edge_s = 1'b1;
`endif
  end

  // Next-state and next-output logic; pixel outputs only move when a write is issued.
  always_comb begin
    state_s = state_r;
    xs_s    = xs_r;
    cx_s    = cx_r;
    cy_s    = cy_r;
    xe_s    = xe_r;
    ye_s    = ye_r;
    fill_s  = fill_r;
    x_s     = x;
    y_s     = y;
    color_s = color;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    plot_s  = 1'b0;
`ifdef RECT_OUTLINE_EN
    ys_s      = ys_r;
    outline_s = outline_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          xs_s   = x0;
          cx_s   = x0;
          cy_s   = y0;
          xe_s   = x_clip_s;
          ye_s   = y_clip_s;
          fill_s = fill_color;
`ifdef RECT_OUTLINE_EN
          ys_s      = y0;
          outline_s = outline;
`endif
          if (empty_s) begin
            state_s = FINISH;
            done_s  = 1'b1;
          end else begin
            state_s = DRAW;
            busy_s  = 1'b1;
            plot_s  = 1'b1;
            x_s     = x0;
            y_s     = y0;
            color_s = fill_color;
          end
        end else begin
          state_s = IDLE;
        end
      end
      DRAW: begin
        if (last_s) begin
          state_s = FINISH;
          done_s  = 1'b1;
        end else begin
          cx_s   = nx_s;
          cy_s   = ny_s;
          busy_s = 1'b1;
          plot_s = edge_s;
          if (edge_s) begin
            x_s     = nx_s;
            y_s     = ny_s;
            color_s = fill_r;
          end else begin
            x_s     = x;
            y_s     = y;
            color_s = color;
          end
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, scan context and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      xs_r    <= {XW{1'b0}};
      cx_r    <= {XW{1'b0}};
      cy_r    <= {YW{1'b0}};
      xe_r    <= {(XW+1){1'b0}};
      ye_r    <= {(YW+1){1'b0}};
      fill_r  <= {CW{1'b0}};
      x       <= {XW{1'b0}};
      y       <= {YW{1'b0}};
      color   <= {CW{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      plot    <= 1'b0;
`ifdef RECT_OUTLINE_EN
      ys_r      <= {YW{1'b0}};
      outline_r <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      xs_r    <= xs_s;
      cx_r    <= cx_s;
      cy_r    <= cy_s;
      xe_r    <= xe_s;
      ye_r    <= ye_s;
      fill_r  <= fill_s;
      x       <= x_s;
      y       <= y_s;
      color   <= color_s;
      busy    <= busy_s;
      done    <= done_s;
      plot    <= plot_s;
`ifdef RECT_OUTLINE_EN
      ys_r      <= ys_s;
      outline_r <= outline_s;
`endif
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: per-cycle traces compared against a pixel-list model.
// Outline scenarios are exercised when RECT_OUTLINE_EN is defined.
module tb_rect_fill_engine;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int MAXT = 256;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [XW-1:0] x0 = '0;
  logic [YW-1:0] y0 = '0;
  logic [XW-1:0] w = '0;
  logic [YW-1:0] h = '0;
  logic [CW-1:0] fill_color = '0;
`ifdef RECT_OUTLINE_EN
  logic          outline = 1'b0;
`endif
  logic          busy, done, plot;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] color;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic outl_sel = 1'b0;

  // expected trace (index = cycles after start was sampled)
  logic          e_plot [MAXT];
  logic          e_busy [MAXT];
  logic          e_done [MAXT];
  logic [XW-1:0] e_x [MAXT];
  logic [YW-1:0] e_y [MAXT];
  logic [CW-1:0] exp_c;
  int            exp_len;
  // recorded trace
  logic          r_plot [MAXT];
  logic          r_busy [MAXT];
  logic          r_done [MAXT];
  logic [XW-1:0] r_x [MAXT];
  logic [YW-1:0] r_y [MAXT];
  logic [CW-1:0] r_c [MAXT];

  rect_fill_engine dut (
    .clk(clk), .resetn(resetn), .start(start),
    .x0(x0), .y0(y0), .w(w), .h(h), .fill_color(fill_color),
`ifdef RECT_OUTLINE_EN
    .outline(outline),
`endif
    .busy(busy), .done(done), .x(x), .y(y), .color(color), .plot(plot)
  );

  always #5 clk = ~clk;

  // Enumerate visible pixels of the clipped rectangle; done follows the last scan cycle.
  task automatic build_model(input int mx0, input int my0, input int mw, input int mh,
                             input logic [CW-1:0] mc);
    int xe, ye, k;
    xe = (mx0 + mw < 160) ? mx0 + mw : 160;
    ye = (my0 + mh < 120) ? my0 + mh : 120;
    for (int i = 0; i < MAXT; i++) begin
      e_plot[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0; e_x[i] = '0; e_y[i] = '0;
    end
    exp_c = mc;
    k = 1;
    for (int yy = my0; yy < ye; yy++) begin
      for (int xx = mx0; xx < xe; xx++) begin
        e_busy[k] = 1'b1;
        e_plot[k] = !outl_sel || xx == mx0 || xx == xe - 1 || yy == my0 || yy == ye - 1;
        e_x[k] = xx[XW-1:0];
        e_y[k] = yy[YW-1:0];
        k++;
      end
    end
    e_done[k] = 1'b1;
    exp_len = k + 2;
  endtask

  // Pulse start from a falling edge and record exp_len-1 cycles; optional extra start at pulse_at.
  task automatic run_rect(input int rx0, input int ry0, input int rw, input int rh,
                          input logic [CW-1:0] rc, input int pulse_at);
    x0 = rx0[XW-1:0]; y0 = ry0[YW-1:0]; w = rw[XW-1:0]; h = rh[YW-1:0]; fill_color = rc;
`ifdef RECT_OUTLINE_EN
    outline = outl_sel;
`endif
    start = 1'b1;
    for (int k = 1; k < exp_len; k++) begin
      @(negedge clk);
      r_plot[k] = plot; r_busy[k] = busy; r_done[k] = done;
      r_x[k] = x; r_y[k] = y; r_c[k] = color;
      start = (k == pulse_at);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    total_cnt++;
    if ({busy, done, plot, x, y, color} !== '0)
      $display("FAIL reset: got busy=%b done=%b plot=%b x=%0d y=%0d c=%0d, want all 0",
               busy, done, plot, x, y, color);
    else pass_cnt++;
  endtask

  task automatic test_fill;
    int cx0 [6] = '{10, 158, 50, 160, 20, 20};
    int cy0 [6] = '{20, 119, 50, 10, 120, 30};
    int cw  [6] = '{3, 5, 0, 4, 3, 3};
    int ch  [6] = '{2, 3, 4, 4, 3, 0};
    int nplot;
    for (int c = 0; c < 6; c++) begin
      build_model(cx0[c], cy0[c], cw[c], ch[c], 3'(c + 5));
      run_rect(cx0[c], cy0[c], cw[c], ch[c], 3'(c + 5), 0);
      nplot = 0;
      for (int k = 1; k < exp_len; k++) begin
        nplot += int'(r_plot[k]);
        total_cnt++;
        if (r_plot[k] !== e_plot[k] || r_busy[k] !== e_busy[k] || r_done[k] !== e_done[k] ||
            (e_plot[k] && (r_x[k] !== e_x[k] || r_y[k] !== e_y[k] || r_c[k] !== exp_c)))
          $display("FAIL fill case %0d cyc %0d: got pbd=%b%b%b (%0d,%0d) c=%0d, want pbd=%b%b%b (%0d,%0d) c=%0d",
                   c, k, r_plot[k], r_busy[k], r_done[k], r_x[k], r_y[k], r_c[k],
                   e_plot[k], e_busy[k], e_done[k], e_x[k], e_y[k], exp_c);
        else pass_cnt++;
      end
      if (c == 0) begin
        total_cnt++;
        if (nplot !== 6 || r_done[7] !== 1'b1)
          $display("FAIL fill basic count: got plots=%0d done@7=%b, want plots=6 done@7=1", nplot, r_done[7]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_random;
    int rx0, ry0, rw, rh;
    logic [CW-1:0] rc;
    for (int n = 0; n < 12; n++) begin
      rx0 = $urandom_range(0, 170); ry0 = $urandom_range(0, 125);
      rw = $urandom_range(0, 12);   rh = $urandom_range(0, 6);
      rc = 3'($urandom_range(0, 7));
`ifdef RECT_OUTLINE_EN
      outl_sel = 1'($urandom_range(0, 1));
`endif
      build_model(rx0, ry0, rw, rh, rc);
      run_rect(rx0, ry0, rw, rh, rc, 0);
      for (int k = 1; k < exp_len; k++) begin
        total_cnt++;
        if (r_plot[k] !== e_plot[k] || r_busy[k] !== e_busy[k] || r_done[k] !== e_done[k] ||
            (e_plot[k] && (r_x[k] !== e_x[k] || r_y[k] !== e_y[k] || r_c[k] !== exp_c)))
          $display("FAIL random rect (%0d,%0d,%0d,%0d) cyc %0d: got pbd=%b%b%b (%0d,%0d) c=%0d, want pbd=%b%b%b (%0d,%0d) c=%0d",
                   rx0, ry0, rw, rh, k, r_plot[k], r_busy[k], r_done[k], r_x[k], r_y[k], r_c[k],
                   e_plot[k], e_busy[k], e_done[k], e_x[k], e_y[k], exp_c);
        else pass_cnt++;
      end
    end
    outl_sel = 1'b0;
  endtask

  task automatic test_back_to_back;
    // run 0: restart during draw; run 1: restart on done; run 2: start the cycle after done
    int pulse [3] = '{3, 7, 0};
    int bx0 [3] = '{10, 10, 70};
    int by0 [3] = '{20, 20, 40};
    for (int r = 0; r < 3; r++) begin
      build_model(bx0[r], by0[r], 3, 2, 3'(r + 1));
      run_rect(bx0[r], by0[r], 3, 2, 3'(r + 1), pulse[r]);
      for (int k = 1; k < exp_len; k++) begin
        total_cnt++;
        if (r_plot[k] !== e_plot[k] || r_busy[k] !== e_busy[k] || r_done[k] !== e_done[k] ||
            (e_plot[k] && (r_x[k] !== e_x[k] || r_y[k] !== e_y[k] || r_c[k] !== exp_c)))
          $display("FAIL back_to_back run %0d cyc %0d: got pbd=%b%b%b (%0d,%0d) c=%0d, want pbd=%b%b%b (%0d,%0d) c=%0d",
                   r, k, r_plot[k], r_busy[k], r_done[k], r_x[k], r_y[k], r_c[k],
                   e_plot[k], e_busy[k], e_done[k], e_x[k], e_y[k], exp_c);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid_draw;
    x0 = 8'd10; y0 = 7'd20; w = 8'd3; h = 7'd2; fill_color = 3'd5;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 resetn = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, plot, x, y, color} !== '0)
      $display("FAIL reset mid draw async: got busy=%b done=%b plot=%b x=%0d y=%0d c=%0d, want all 0",
               busy, done, plot, x, y, color);
    else pass_cnt++;
    repeat (3) begin
      @(negedge clk);
      total_cnt++;
      if (done !== 1'b0 || plot !== 1'b0 || busy !== 1'b0)
        $display("FAIL reset mid draw hold: got done=%b plot=%b busy=%b, want 000", done, plot, busy);
      else pass_cnt++;
    end
    resetn = 1'b1;
    @(negedge clk);
    build_model(40, 60, 4, 3, 3'd2);
    run_rect(40, 60, 4, 3, 3'd2, 0);
    for (int k = 1; k < exp_len; k++) begin
      total_cnt++;
      if (r_plot[k] !== e_plot[k] || r_busy[k] !== e_busy[k] || r_done[k] !== e_done[k] ||
          (e_plot[k] && (r_x[k] !== e_x[k] || r_y[k] !== e_y[k] || r_c[k] !== exp_c)))
        $display("FAIL after reset cyc %0d: got pbd=%b%b%b (%0d,%0d) c=%0d, want pbd=%b%b%b (%0d,%0d) c=%0d",
                 k, r_plot[k], r_busy[k], r_done[k], r_x[k], r_y[k], r_c[k],
                 e_plot[k], e_busy[k], e_done[k], e_x[k], e_y[k], exp_c);
      else pass_cnt++;
    end
  endtask

`ifdef RECT_OUTLINE_EN
  task automatic test_outline;
    int nplot;
    outl_sel = 1'b1;
    build_model(0, 0, 4, 3, 3'd4);
    run_rect(0, 0, 4, 3, 3'd4, 0);
    nplot = 0;
    for (int k = 1; k < exp_len; k++) begin
      nplot += int'(r_plot[k]);
      total_cnt++;
      if (r_plot[k] !== e_plot[k] || r_busy[k] !== e_busy[k] || r_done[k] !== e_done[k] ||
          (e_plot[k] && (r_x[k] !== e_x[k] || r_y[k] !== e_y[k] || r_c[k] !== exp_c)))
        $display("FAIL outline cyc %0d: got pbd=%b%b%b (%0d,%0d) c=%0d, want pbd=%b%b%b (%0d,%0d) c=%0d",
                 k, r_plot[k], r_busy[k], r_done[k], r_x[k], r_y[k], r_c[k],
                 e_plot[k], e_busy[k], e_done[k], e_x[k], e_y[k], exp_c);
      else pass_cnt++;
    end
    total_cnt++;
    if (nplot !== 10 || r_done[13] !== 1'b1)
      $display("FAIL outline count: got plots=%0d done@13=%b, want plots=10 done@13=1", nplot, r_done[13]);
    else pass_cnt++;
    outl_sel = 1'b0;
  endtask
`endif

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    test_fill();
    test_back_to_back();
    test_reset_mid_draw();
`ifdef RECT_OUTLINE_EN
    test_outline();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
